// File: rtl/decoder_2to4_stretch.sv
`default_nettype none
// ============================================================================
// Module   : decoder_2to4_stretch
// Brief    : FIFO-buffered 2-to-4 decoder that stretches each one-hot pulse
//            to HOLD_CYCLES with GAP_CYCLES idle cycles between pulses.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_2to4_stretch #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int DEPTH       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in_code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] out,
  output logic       out_valid,
  output logic       busy,
  output logic [2:0] fifo_level
);

  localparam int              c_PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [7:0]      c_HOLD_LOAD = 8'(c_HOLD_EFF - 1);
  localparam logic [7:0]      c_GAP_LOAD  = 8'((GAP_CYCLES < 1) ? 0 : GAP_CYCLES - 1);
  localparam logic [2:0]      c_DEPTH     = 3'(DEPTH);
  localparam logic [c_PW-1:0] c_PTR_LAST  = c_PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic [3:0]      r_out, w_out_nxt;
  logic            r_out_valid;
  logic [1:0]      r_mem [DEPTH];
  logic [c_PW-1:0] r_wptr, r_rptr;
  logic [2:0]      r_level;
  logic            w_push, w_pop, w_fifo_ne;
  logic [1:0]      w_head;

  function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Ready comes from the registered level only, so a same-edge pop never frees a slot early.
  assign in_ready  = (r_level < c_DEPTH);
  assign w_push    = in_valid && in_ready;
  assign w_fifo_ne = (r_level != 3'd0);
  assign w_head    = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= 3'd0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 3'd1;
        2'b01:   r_level <= r_level - 3'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_out_nxt = 4'b0000;
        if (w_fifo_ne) begin
          w_pop       = 1'b1;
          w_out_nxt   = 4'b0001 << w_head;
          w_cnt_nxt   = c_HOLD_LOAD;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else if (GAP_CYCLES == 0) begin
          // No gap: chain straight into the next queued code without a zero cycle.
          if (w_fifo_ne) begin
            w_pop     = 1'b1;
            w_out_nxt = 4'b0001 << w_head;
            w_cnt_nxt = c_HOLD_LOAD;
          end else begin
            w_out_nxt   = 4'b0000;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_out_nxt   = 4'b0000;
          w_cnt_nxt   = c_GAP_LOAD;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        w_out_nxt = 4'b0000;
        if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else if (w_fifo_ne) begin
          w_pop       = 1'b1;
          w_out_nxt   = 4'b0001 << w_head;
          w_cnt_nxt   = c_HOLD_LOAD;
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_out_nxt   = 4'b0000;
        w_cnt_nxt   = 8'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_out       <= 4'b0000;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= (w_out_nxt != 4'b0000);
    end
  end

  assign out        = r_out;
  assign out_valid  = r_out_valid;
  assign fifo_level = r_level;
  assign busy       = (r_state != S_IDLE) || w_fifo_ne;

endmodule
`default_nettype wire

// File: doc/decoder_2to4_stretch.md
Name: decoder_2to4_stretch

Overview:
- Sequential counterpart to the team's 4-to-2 priority encoder: accepts 2-bit encoded indices over a valid/ready handshake and drives the matching one-hot 4-bit output line.
- Buffers codes in a small FIFO and holds each one-hot pulse for a programmable number of cycles, with a programmable idle gap between pulses.
- Used to replay encoded events onto discrete strobe/LED/select lines.

Parameters:
- HOLD_CYCLES, 4, cycles each one-hot pulse stays asserted; legal 1..255; a value of 0 is treated as 1.
- GAP_CYCLES, 1, all-zero cycles inserted between consecutive pulses; legal 0..255.
- DEPTH, 2, FIFO entries; legal 1..4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_code  input  2  encoded index; 3 selects out[3], 0 selects out[0]
- in_valid  input  1  in_code is valid this cycle
- in_ready  output  1  FIFO can accept; handshake occurs when in_valid && in_ready at a rising edge
- out  output  4  registered one-hot output; all-zero when no pulse is active
- out_valid  output  1  registered; high exactly when out != 0
- busy  output  1  high when state != IDLE or the FIFO is non-empty
- fifo_level  output  3  registered FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (rst high at an edge):
  - out = 4'b0000, out_valid = 0, fifo_level = 0, state = IDLE, counter = 0, FIFO flushed.
  - in_ready = 1 and busy = 0 in the cycle after reset.
  - Reset mid-pulse clears out at that same edge; queued codes are discarded.
- in_ready = (fifo_level < DEPTH), computed from the registered level only. There is no pass-through when full: in_ready stays 0 even in a cycle where a pop occurs.
- Push and pop at the same edge leave fifo_level unchanged. The FIFO is in-order, with a wrap-around pointer of width clog2(DEPTH).
- Decode: out = 4'b0001 << code; codes are never invalid.
- State machine: IDLE, HOLD, GAP.
  - IDLE: if FIFO non-empty at an edge, pop the head, load out, set counter = HOLD_CYCLES-1, go to HOLD. Otherwise out = 0.
  - HOLD: out is held. If counter != 0, decrement.
    - If counter == 0 and GAP_CYCLES == 0 and the FIFO is non-empty: pop the next code and load it directly, giving back-to-back pulses with no zero cycle. Stay in HOLD with counter reloaded.
    - If counter == 0 and GAP_CYCLES == 0 and the FIFO is empty: out = 0, go to IDLE.
    - If counter == 0 and GAP_CYCLES > 0: out = 0, counter = GAP_CYCLES-1, go to GAP.
  - GAP: out = 0. If counter != 0, decrement. If counter == 0:
    - FIFO non-empty: pop, load out, go to HOLD with counter = HOLD_CYCLES-1.
    - FIFO empty: go to IDLE.
- Latency: a handshake sampled at edge k into an empty FIFO in IDLE writes the FIFO at edge k. Out is loaded at edge k+1 and is high for exactly HOLD_CYCLES cycles.
- Spacing: between consecutive queued pulses there are exactly GAP_CYCLES all-zero cycles.
- A code pushed while the FSM is in HOLD/GAP waits in the FIFO; no pulse is ever shortened or dropped.
- A pop and a push of a new code at the same edge with level 1: the level stays 1, and the new code is the next head.
- out_valid is registered alongside out and never differs from (out != 0).

Test Plan:
1. Reset check: assert rst for 2 cycles, then release → out = 0, out_valid = 0, fifo_level = 0, in_ready = 1, busy = 0.
2. Single pulse (HOLD=4, GAP=1): push code 2 at edge k → out = 4'b0100 from edge k+1 for exactly 4 cycles, then 0. busy drops at the end of the gap, returning to IDLE.
3. Queue full (DEPTH=2, HOLD=4, GAP=1): hold in_valid high with codes 0, 3, 1 on consecutive cycles.
   - Code 0 is popped to out at edge k+1 while code 3 is pushed.
   - Code 1 is pushed at edge k+2, reaching fifo_level = 2 with in_ready = 0.
   - Expect out = 0001×4, 0×1, 1000×4, 0×1, 0010×4.
4. Back-to-back (GAP=0, HOLD=2): push 0 then 3 → out = 0001, 0001, 1000, 1000 with no zero cycle in between.
5. Reset mid-pulse: push code 1, assert rst on the 2nd HOLD cycle with one code queued → out = 0 and fifo_level = 0 after that edge; no further pulse follows.
6. Simultaneous push/pop at fifo_level = 1 (HOLD end, GAP=0) → fifo_level stays 1, and the pulse order matches push order.
